alu_cmd_driver: RTL
===================

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter WIDTH, default 128: operand and result width.
REQ-002 Parameter LAT, default 2: ALU edges from operand presentation to result valid (LAT>=1).
REQ-003 Parameter DEPTH, default 4: response FIFO entries (power of 2, >=2).
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-005 rst input 1: asynchronous, active-high reset.
REQ-006 cmd_valid input 1 / cmd_ready output 1: command handshake; a command transfers on a clk edge with both high.
REQ-007 cmd_opcode input 4, cmd_a input WIDTH, cmd_b input WIDTH, cmd_shift input 5, cmd_tag input 4: command payload.
REQ-008 alu_opcode output 4, alu_input1 output WIDTH, alu_input2 output WIDTH, alu_shiftValue output 5: registered drive into the pipelined ALU.
REQ-009 alu_result input WIDTH, alu_carry input 1, alu_zero input 1, alu_ovf input 1: ALU registered outputs.
REQ-010 rsp_valid output 1 / rsp_ready input 1: response handshake; a response pops on a clk edge with both high.
REQ-011 rsp_result output WIDTH, rsp_flags output 3 ({ovf,zero,carry}), rsp_tag output 4, rsp_err output 1: response payload, head of FIFO.
REQ-012 busy output 1: high while any command is in flight or the FIFO is non-empty.

Function
REQ-013 On command accept, alu_* outputs SHALL load cmd_opcode/cmd_a/cmd_b/cmd_shift on that edge and hold until the next accept.
REQ-014 With no accept, alu_* outputs SHALL hold their previous values; results of idle cycles SHALL NOT be captured.
REQ-015 An issue-tracking shift register LAT+1 stages deep SHALL carry {valid, tag, err} per accepted command, shifting every edge.
REQ-016 A command accepted at edge N SHALL have alu_result/flags written into the FIFO at edge N+LAT+1, together with its tag and err.
REQ-017 With LAT=2 and an empty FIFO, rsp_valid SHALL rise 3 cycles after the accept edge.
REQ-018 rsp_err SHALL be 1 when the captured cmd_opcode > 4'd10, else 0; the command is still issued and its response still produced.
REQ-019 Responses SHALL leave the FIFO in acceptance order; rsp_* SHALL show the head entry while rsp_valid=1.
REQ-020 Credit counter: credits = DEPTH - fifo_count - inflight, reset to DEPTH; decrement on accept, increment on pop; never <0 or >DEPTH.
REQ-021 cmd_ready SHALL be a function of registered state only: 1 iff credits>0; a pop SHALL NOT raise cmd_ready in the same cycle.
REQ-022 Simultaneous accept and pop in one cycle SHALL leave credits unchanged.
REQ-023 Simultaneous FIFO write and pop SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-024 The FIFO SHALL never overflow; a write with fifo full is unreachable by REQ-020 and SHALL be flagged by an assertion.
REQ-025 rsp_valid=0 SHALL ignore rsp_ready; cmd_ready=0 SHALL ignore cmd_valid.

Reset
REQ-026 While rst=1: cmd_ready=0, rsp_valid=0, busy=0, all alu_* outputs 0, rsp_* outputs 0, credits=DEPTH, tracking register cleared.
REQ-027 Reset mid-operation SHALL discard all in-flight commands and FIFO contents; no stale response SHALL appear after release.
REQ-028 cmd_ready SHALL be 1 on the first clk edge after rst deasserts.

Verification
REQ-029 ADD (op 0) a=5, b=7, tag 3 accepted at edge 0, rsp_ready=1 -> rsp_valid at edge 3, rsp_result=12, rsp_flags=000, rsp_tag=3, rsp_err=0.
REQ-030 SUB (op 1) a=0, b=1 -> rsp_result=all ones, rsp_flags[0] carry=1.
REQ-031 Five back-to-back commands, rsp_ready=0, DEPTH=4 -> cmd_ready low after the 4th accept; the 5th is held; FIFO holds tags in order; each pop releases one credit.
REQ-032 At credits=0, one pop and cmd_valid=1 in the same cycle -> no accept that cycle; accept occurs on the following edge.
REQ-033 opcode 4'd12, tag 9 -> rsp_err=1, rsp_tag=9, response count unchanged.
REQ-034 rst pulsed with 2 commands in flight and 1 in FIFO -> after release rsp_valid stays 0 for 5 cycles, credits=DEPTH, busy=0.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - credit-flow command driver for a pipelined ALU with in-order response FIFO
module alu_cmd_driver #(
    parameter int WIDTH = 128,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shift,
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [3:0]       rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  cmd_accept;
    logic                  rsp_pop;
    logic                  fifo_wr;
    logic                  ready_q;
    logic [LAT:0]          trk_valid;
    logic [LAT:0]          trk_err;
    logic [LAT:0][3:0]     trk_tag;
    logic [WIDTH-1:0]      mem_result [DEPTH];
    logic [2:0]            mem_flags  [DEPTH];
    logic [3:0]            mem_tag    [DEPTH];
    logic [DEPTH-1:0]      mem_err;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         credits;
    logic [CW-1:0]         credits_next;

    assign cmd_accept = cmd_valid & ready_q;
    assign rsp_pop    = rsp_valid & rsp_ready;
    assign fifo_wr    = trk_valid[LAT];
    assign cmd_ready  = ready_q;
    assign rsp_valid  = (fifo_count != '0);
    assign busy       = rsp_valid | (|trk_valid);

    // Head entry is masked to zero while empty so reset shows clean outputs.
    assign rsp_result = rsp_valid ? mem_result[rd_ptr] : '0;
    assign rsp_flags  = rsp_valid ? mem_flags[rd_ptr]  : '0;
    assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr]    : '0;
    assign rsp_err    = rsp_valid & mem_err[rd_ptr];

    always_comb begin
        credits_next = credits;
        if (cmd_accept && !rsp_pop)
            credits_next = credits - CW'(1);
        else if (rsp_pop && !cmd_accept)
            credits_next = credits + CW'(1);
    end

    // One stage per ALU edge plus the capture edge; the last stage marks the result as live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_valid <= '0;
            trk_err   <= '0;
            trk_tag   <= '0;
        end else begin
            trk_valid <= {trk_valid[LAT-1:0], cmd_accept};
            trk_err   <= {trk_err[LAT-1:0], (cmd_opcode > 4'd10)};
            trk_tag   <= {trk_tag[LAT-1:0], cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            credits        <= CW'(DEPTH);
            ready_q        <= 1'b0;
        end else begin
            if (cmd_accept) begin
                alu_opcode     <= cmd_opcode;
                alu_input1     <= cmd_a;
                alu_input2     <= cmd_b;
                alu_shiftValue <= cmd_shift;
            end
            if (fifo_wr)
                wr_ptr <= wr_ptr + PW'(1);
            if (rsp_pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(fifo_wr) - CW'(rsp_pop);
            credits    <= credits_next;
            ready_q    <= (credits_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_result[wr_ptr] <= alu_result;
            mem_flags[wr_ptr]  <= {alu_ovf, alu_zero, alu_carry};
            mem_tag[wr_ptr]    <= trk_tag[LAT];
            mem_err[wr_ptr]    <= trk_err[LAT];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && (fifo_count == CW'(DEPTH))));
    a_credit_range: assert property (@(posedge clk) disable iff (rst)
        credits <= CW'(DEPTH));

endmodule
